// File: rtl/melody_sequencer.sv
// ----------------------------------------------------------------------------
// melody_sequencer
// Plays a small table of notes. Each entry holds a half-period (in clock
// cycles, 0 = rest) and a duration in units of TICK_DIV clock cycles. The
// current half-period is presented to a downstream tone generator together
// with a gate that is high while a non-rest note plays.
//
// Flow per note: one FETCH cycle to read the table entry, then PLAY for
// duration*TICK_DIV cycles. After the last active entry the sequence either
// wraps to entry 0 (loop level high) or returns to IDLE with a done pulse.
// ----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int TICK_DIV = 6_250_000,
    parameter int DEPTH    = 16
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iWE,
    input  logic [3:0]  iWADDR,
    input  logic [24:0] iWDATA,
    input  logic [4:0]  iLEN,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic        iLOOP,
    output logic [20:0] oHALF_PERIOD,
    output logic        oGATE,
    output logic [3:0]  oSTEP,
    output logic        oBUSY,
    output logic        oDONE
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;

    // Last value of the tick counter within one duration unit.
    localparam logic [22:0] TICK_LAST = 23'(TICK_DIV - 1);

    // Largest sequence length the table can actually back.
    localparam logic [4:0] LEN_MAX = 5'(DEPTH);

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [24:0] note_table [DEPTH];

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [4:0]  len_q;        // active entries latched at start
    logic [3:0]  step;         // index of the current entry
    logic [20:0] half_period;  // half-period of the current note
    logic [3:0]  dur;          // effective duration of the current note (>= 1)
    logic [22:0] tick_cnt;     // clock cycles within the current unit
    logic [3:0]  unit_cnt;     // units elapsed within the current note
    logic        done;

    // ------------------------------------------------------------------------
    // Decoded conditions
    // ------------------------------------------------------------------------
    logic [24:0] fetch_entry;
    logic [3:0]  fetch_dur;
    logic        tick_wrap;
    logic        unit_wrap;
    logic        play_end;
    logic        last_entry;
    logic        start_ok;
    logic        finish_seq;
    logic        wr_ok;

    // Table write port: writes are accepted in any state.
    assign wr_ok = iRST_N && iWE && (int'(iWADDR) < DEPTH);

    // Note table register file, written on any cycle with the strobe high.
    // NOTE: the table has no reset; its contents are only meaningful once written,
    //       and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge iCLK) begin
        if (wr_ok) begin
            note_table[iWADDR] <= iWDATA;
        end
    end

    // Combinational decode of counters, table read and sequence position.
    // NOTE: every signal in this block gets a default first so no latch is inferred.
    always_comb begin
        fetch_entry = note_table[step];
        fetch_dur   = (fetch_entry[3:0] == 4'd0) ? 4'd1 : fetch_entry[3:0];
        tick_wrap   = (tick_cnt == TICK_LAST);
        unit_wrap   = (unit_cnt == (dur - 4'd1));
        play_end    = (state == S_PLAY) && tick_wrap && unit_wrap;
        last_entry  = ({1'b0, step} >= (len_q - 5'd1));
        start_ok    = iSTART && !iSTOP && (iLEN != 5'd0);
        finish_seq  = play_end && last_entry && !iLOOP;
    end

    // Next-state selection; a stop request wins over everything else.
    always_comb begin
        state_nx = state;
        if (iSTOP) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state_nx = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_nx = S_PLAY;
                end
                S_PLAY: begin
                    if (play_end) begin
                        state_nx = (!last_entry || iLOOP) ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge values of the others.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sequence length, captured only when a start request is accepted.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            len_q <= 5'd0;
        end else if ((state == S_IDLE) && start_ok) begin
            len_q <= (iLEN > LEN_MAX) ? LEN_MAX : iLEN;
        end
    end

    // Entry index: cleared on start/stop, advanced or wrapped at note end.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            step <= 4'd0;
        end else if (iSTOP) begin
            step <= 4'd0;
        end else if ((state == S_IDLE) && start_ok) begin
            step <= 4'd0;
        end else if (play_end) begin
            step <= last_entry ? 4'd0 : (step + 4'd1);
        end
    end

    // Current note: loaded in FETCH, held through PLAY, cleared when idle.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            half_period <= 21'd0;
            dur         <= 4'd0;
        end else if (iSTOP || finish_seq) begin
            half_period <= 21'd0;
            dur         <= 4'd0;
        end else if (state == S_FETCH) begin
            half_period <= fetch_entry[24:4];
            dur         <= fetch_dur;
        end
    end

    // Duration timing: tick counter rolls every TICK_DIV cycles into units.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            tick_cnt <= 23'd0;
            unit_cnt <= 4'd0;
        end else if (iSTOP || (state != S_PLAY)) begin
            tick_cnt <= 23'd0;
            unit_cnt <= 4'd0;
        end else if (tick_wrap) begin
            tick_cnt <= 23'd0;
            unit_cnt <= unit_wrap ? 4'd0 : (unit_cnt + 4'd1);
        end else begin
            tick_cnt <= tick_cnt + 23'd1;
        end
    end

    // One-cycle completion pulse on the natural end of a non-looping run.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            done <= 1'b0;
        end else begin
            done <= !iSTOP && finish_seq;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign oHALF_PERIOD = half_period;
    assign oGATE        = (state == S_PLAY) && (half_period != 21'd0);
    assign oSTEP        = step;
    assign oBUSY        = (state != S_IDLE);
    assign oDONE        = done;

endmodule
